// File: rtl/cla_serial_signed_sub_if.sv
// Operand/result handshake bundle for cla_serial_signed_sub.
// The slave side is the subtractor. The master side is the producer/consumer.
interface cla_serial_signed_sub_if #(
  parameter int DATA_IN_W = 16
);
  logic                 valid_i;
  logic                 ready_o;
  logic [DATA_IN_W-1:0] inp_A_i;
  logic [DATA_IN_W-1:0] inp_B_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DATA_IN_W-1:0] diff_o;
  logic                 borrow_o;
  logic                 overflow_o;

  modport slave (
    input  valid_i, inp_A_i, inp_B_i, ready_i,
    output ready_o, valid_o, diff_o, borrow_o, overflow_o
  );

  modport master (
    output valid_i, inp_A_i, inp_B_i, ready_i,
    input  ready_o, valid_o, diff_o, borrow_o, overflow_o
  );
endinterface

// File: rtl/cla_serial_signed_sub.sv
// Digit-serial signed subtractor A - B = A + ~B + 1, one SLICE_W-bit CLA slice per clock.
// Optional macro CLA_SUB_SATURATE_EN clamps diff_o on signed overflow.
module cla_serial_signed_sub #(
  parameter int DATA_IN_W = 16,
  parameter int SLICE_W   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  cla_serial_signed_sub_if.slave  bus
);
  localparam int N   = DATA_IN_W / SLICE_W;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = DATA_IN_W - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [DATA_IN_W-1:0] a_q, nb_q, acc;
  logic                 carry_q;
  logic [CW-1:0]        cnt;

  logic [SLICE_W-1:0]   sa, sb, g, p, sum;
  logic [SLICE_W:0]     c;
  logic                 pp;
  logic [DATA_IN_W-1:0] acc_nxt, res;
  logic                 a_msb, b_msb, ovf;

  // Slice carries in flattened lookahead form: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    sa  = a_q[cnt*SLICE_W +: SLICE_W];
    sb  = nb_q[cnt*SLICE_W +: SLICE_W];
    g   = sa & sb;
    p   = sa ^ sb;
    c   = '0;
    pp  = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & carry_q);
    end
    sum = p ^ c[SLICE_W-1:0];

    acc_nxt = acc;
    acc_nxt[cnt*SLICE_W +: SLICE_W] = sum;

    a_msb = a_q[MSB];
    b_msb = ~nb_q[MSB];
    ovf   = (a_msb != b_msb) && (acc_nxt[MSB] != a_msb);
`ifdef CLA_SUB_SATURATE_EN
    if (ovf) res = a_msb ? {1'b1, {(DATA_IN_W-1){1'b0}}} : {1'b0, {(DATA_IN_W-1){1'b1}}};
    else     res = acc_nxt;
`else
    res = acc_nxt;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      a_q            <= '0;
      nb_q           <= '0;
      acc            <= '0;
      carry_q        <= 1'b0;
      cnt            <= '0;
      bus.diff_o     <= '0;
      bus.borrow_o   <= 1'b0;
      bus.overflow_o <= 1'b0;
      bus.valid_o    <= 1'b0;
      bus.ready_o    <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.valid_i) begin
          a_q         <= bus.inp_A_i;
          nb_q        <= ~bus.inp_B_i;
          carry_q     <= 1'b1;
          cnt         <= '0;
          state       <= BUSY;
          bus.ready_o <= 1'b0;
        end
        BUSY: begin
          acc     <= acc_nxt;
          carry_q <= c[SLICE_W];
          if (cnt == CW'(N - 1)) begin
            // Result registers only change here, so they hold through the next operation
            state          <= DONE;
            bus.valid_o    <= 1'b1;
            bus.diff_o     <= res;
            bus.borrow_o   <= ~c[SLICE_W];
            bus.overflow_o <= ovf;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (bus.ready_i) begin
          state       <= IDLE;
          bus.valid_o <= 1'b0;
          bus.ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_signed_sub.sv
// Directed plus randomized bench for cla_serial_signed_sub against an arithmetic reference.
module tb_cla_serial_signed_sub;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  cla_serial_signed_sub_if #(.DATA_IN_W(W)) bif ();

  cla_serial_signed_sub #(.DATA_IN_W(W), .SLICE_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    longint ua, ub, sa, sb, sd;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - 65536 : ua;
    sb = b[W-1] ? ub - 65536 : ub;
    sd = sa - sb;
    bo = (ua < ub);
    ov = (sd > 32767) || (sd < -32768);
    d  = W'((ua - ub + 65536) % 65536);
`ifdef CLA_SUB_SATURATE_EN
    if (ov) d = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bif.ready_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("ready_timeout", 32'(bif.ready_o), 32'd1);
  endtask

  // One operation; hold > 0 keeps ready_i low in DONE while junk operands are offered
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           lat;
    model(a, b, ed, eb, eo);
    wait_ready();
    bif.ready_i = 1'b0;
    bif.valid_i = 1'b1;
    bif.inp_A_i = a;
    bif.inp_B_i = b;
    @(negedge clk);
    bif.valid_i = 1'b0;
    bif.inp_A_i = W'($urandom);
    bif.inp_B_i = W'($urandom);
    check("busy_ready", 32'(bif.ready_o), 32'd0);
    lat = 0;
    while (bif.valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(N));
    check("diff", 32'(bif.diff_o), 32'(ed));
    check("borrow", 32'(bif.borrow_o), 32'(eb));
    check("overflow", 32'(bif.overflow_o), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      bif.valid_i = ~bif.valid_i;
      bif.inp_A_i = W'($urandom);
      bif.inp_B_i = W'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(bif.valid_o), 32'd1);
      check("hold_ready", 32'(bif.ready_o), 32'd0);
      check("hold_diff", 32'(bif.diff_o), 32'(ed));
      check("hold_flags", {30'd0, bif.borrow_o, bif.overflow_o}, {30'd0, eb, eo});
    end
    bif.ready_i = 1'b1;
    @(negedge clk);
    bif.ready_i = 1'b0;
    bif.valid_i = 1'b0;
    check("post_valid", 32'(bif.valid_o), 32'd0);
    check("post_ready", 32'(bif.ready_o), 32'd1);
    if (hold > 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_capture", {30'd0, bif.ready_o, bif.valid_o}, 32'd2);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bif.valid_i = 1'b0;
    bif.ready_i = 1'b0;
    bif.inp_A_i = '0;
    bif.inp_B_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_diff", 32'(bif.diff_o), 32'd0);
    check("rst_flags", {30'd0, bif.borrow_o, bif.overflow_o}, 32'd0);
    check("rst_valid", 32'(bif.valid_o), 32'd0);
    check("rst_ready", 32'(bif.ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0005, 16'h0003, 0);
    check("d_5m3", 32'(bif.diff_o), 32'h0002);
    run_op(16'h0003, 16'h0005, 0);
    check("d_3m5", 32'(bif.diff_o), 32'hFFFE);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h7FFF, 16'hFFFF, 10);

    // Async reset in the middle of slice 2; flags from the previous op are nonzero here
    wait_ready();
    bif.valid_i = 1'b1;
    bif.inp_A_i = 16'h4321;
    bif.inp_B_i = 16'h0021;
    @(negedge clk);
    bif.valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_diff", 32'(bif.diff_o), 32'd0);
    check("arst_flags", {30'd0, bif.borrow_o, bif.overflow_o}, 32'd0);
    check("arst_valid", 32'(bif.valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_ready", 32'(bif.ready_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("arst_no_stale", 32'(bif.valid_o), 32'd0);
    end
    run_op(16'h1234, 16'h0234, 0);
    check("d_after_rst", 32'(bif.diff_o), 32'h1000);

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 6 == 0) rb = ra;
      run_op(ra, rb, (k % 5 == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
